dmem_ctrl: RTL and testbench

//  Data-memory responder for the core's dmem request interface (req/wr/size/zero_ex/addr/wdata).

---
 rtl/risc_pkg.sv | 36 +++
 rtl/dmem_sram.sv | 36 +++
 rtl/dmem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Types and helpers shared by the core control path and the data-memory controller.
package risc_pkg;

    typedef enum logic [1:0] {
        OP_DMEM_BYTE = 2'd0,
        OP_DMEM_HALF = 2'd1,
        OP_DMEM_WORD = 2'd2
    } op_enum_dmem_size;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'd0,
        DMEM_BEAT0 = 2'd1,
        DMEM_BEAT1 = 2'd2,
        DMEM_RESP  = 2'd3
    } op_enum_dmem_state;

    localparam int unsigned DMEM_LANES  = 4;
    localparam int unsigned DMEM_WAIT_W = 4;

    function automatic logic [2:0] dmem_nbytes(input op_enum_dmem_size size);
        case (size)
            OP_DMEM_BYTE: return 3'd1;
            OP_DMEM_HALF: return 3'd2;
            default:      return 3'd4;
        endcase
    endfunction

    function automatic logic [DMEM_LANES-1:0] dmem_lane_mask(input op_enum_dmem_size size);
        case (size)
            OP_DMEM_BYTE: return 4'b0001;
            OP_DMEM_HALF: return 4'b0011;
            default:      return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
module dmem_sram
    import risc_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DMEM_LANES-1:0] i_be,
    input  logic [AW-1:0]         i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < int'(DMEM_LANES); b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: sized/extended loads and stores over a word SRAM, splitting
// word-crossing accesses into two beats and returning one completion pulse per request.
module dmem_ctrl
    import risc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmem_req,
    input  logic             dmem_wr,
    input  op_enum_dmem_size dmem_size,
    input  logic             dmem_zero_ex,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  dmem_wdata,
    output logic             dmem_ready,
    output logic             dmem_rvalid,
    output logic [XLEN-1:0]  dmem_rdata,
    output logic             dmem_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [DMEM_WAIT_W-1:0] WAIT_CNT = DMEM_WAIT_W'(WAIT_STATES);

    op_enum_dmem_state      r_state, w_state_d;
    logic [DMEM_WAIT_W-1:0] r_cnt, w_cnt_d;

    // Request captured at accept
    logic                   r_wr;
    op_enum_dmem_size       r_size;
    logic                   r_zero_ex;
    logic [1:0]             r_off;
    logic [AW-1:0]          r_k;
    logic [31:0]            r_wdata;
    logic                   r_split;
    logic                   r_err;
    logic [31:0]            r_w0;

    logic                   r_rvalid;
    logic [XLEN-1:0]        r_rdata;
    logic                   r_rerr;

    logic                   w_accept;
    logic [2:0]             w_nbytes;
    logic [XLEN:0]          w_last;
    logic                   w_err;
    logic                   w_split;

    logic [7:0]             w_lane_be;
    logic [63:0]            w_lane_wdata;
    logic [AW-1:0]          w_k1;

    logic                   w_sram_en;
    logic                   w_sram_we;
    logic [DMEM_LANES-1:0]  w_sram_be;
    logic [AW-1:0]          w_sram_addr;
    logic [31:0]            w_sram_wdata;
    logic [31:0]            w_sram_rdata;
    logic                   w_capture_w0;

    logic [31:0]            w_w0;
    logic [31:0]            w_w1;
    logic [31:0]            w_raw;
    logic [XLEN-1:0]        w_ext;

    assign w_accept = (r_state == DMEM_IDLE) && dmem_req;
    assign w_nbytes = dmem_nbytes(dmem_size);
    // Wide sum so an access running past the top of the address space cannot wrap to "in range"
    assign w_last   = {1'b0, dmem_addr} + (XLEN+1)'(w_nbytes) - (XLEN+1)'(1);
    assign w_err    = (w_last >= LIMIT);
    assign w_split  = (({1'b0, dmem_addr[1:0]} + w_nbytes) > 3'd4);

    // Byte lanes and data for both beats: low half goes to word k, high half to word k+1
    assign w_lane_be    = {4'b0000, dmem_lane_mask(r_size)} << r_off;
    assign w_lane_wdata = {32'h0, r_wdata} << {r_off, 3'b000};
    assign w_k1         = r_k + AW'(1);

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_sram_en    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_be    = '0;
        w_sram_addr  = r_k;
        w_sram_wdata = w_lane_wdata[31:0];
        w_capture_w0 = 1'b0;
        unique case (r_state)
            DMEM_IDLE: begin
                if (dmem_req) begin
                    w_state_d = w_err ? DMEM_RESP : DMEM_BEAT0;
                    w_cnt_d   = WAIT_CNT;
                end
            end
            DMEM_BEAT0: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - 1'b1;
                end else begin
                    w_sram_en    = 1'b1;
                    w_sram_we    = r_wr;
                    w_sram_be    = w_lane_be[3:0];
                    w_sram_addr  = r_k;
                    w_sram_wdata = w_lane_wdata[31:0];
                    if (r_split) begin
                        w_state_d = DMEM_BEAT1;
                        w_cnt_d   = WAIT_CNT;
                    end else begin
                        w_state_d = DMEM_RESP;
                    end
                end
            end
            DMEM_BEAT1: begin
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - 1'b1;
                end else begin
                    w_sram_en    = 1'b1;
                    w_sram_we    = r_wr;
                    w_sram_be    = w_lane_be[7:4];
                    w_sram_addr  = w_k1;
                    w_sram_wdata = w_lane_wdata[63:32];
                    // SRAM output still holds word k until this read replaces it
                    w_capture_w0 = 1'b1;
                    w_state_d    = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                w_state_d = DMEM_IDLE;
            end
            default: begin
                w_state_d = DMEM_IDLE;
            end
        endcase
        // A reset edge must not let a pending beat touch the array
        if (!rst_n) begin
            w_sram_en = 1'b0;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (w_sram_we),
        .i_be    (w_sram_be),
        .i_addr  (w_sram_addr),
        .i_wdata (w_sram_wdata),
        .o_rdata (w_sram_rdata)
    );

    assign w_w0  = r_split ? r_w0 : w_sram_rdata;
    assign w_w1  = r_split ? w_sram_rdata : 32'h0;
    assign w_raw = 32'({w_w1, w_w0} >> {r_off, 3'b000});

    always_comb begin
        w_ext = '0;
        case (r_size)
            OP_DMEM_BYTE: w_ext = {{(XLEN-8){w_raw[7] & ~r_zero_ex}}, w_raw[7:0]};
            OP_DMEM_HALF: w_ext = {{(XLEN-16){w_raw[15] & ~r_zero_ex}}, w_raw[15:0]};
            default:      w_ext = XLEN'(w_raw);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= DMEM_IDLE;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_rvalid <= 1'b0;
            if (r_state == DMEM_RESP) begin
                r_rvalid <= 1'b1;
                r_rerr   <= r_err;
                if (!r_wr) begin
                    r_rdata <= r_err ? '0 : w_ext;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr      <= dmem_wr;
            r_size    <= dmem_size;
            r_zero_ex <= dmem_zero_ex;
            r_off     <= dmem_addr[1:0];
            r_k       <= dmem_addr[AW+1:2];
            r_wdata   <= dmem_wdata[31:0];
            r_split   <= w_split;
            r_err     <= w_err;
        end
        if (w_capture_w0) begin
            r_w0 <= w_sram_rdata;
        end
    end

    assign dmem_ready  = (r_state == DMEM_IDLE);
    assign dmem_rvalid = r_rvalid;
    assign dmem_rdata  = r_rdata;
    assign dmem_err    = r_rerr;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed and random accesses on a no-wait instance and a two-wait-state
// instance, checked against a byte-array memory model.
module tb_dmem_ctrl;
    import risc_pkg::*;

    logic             clk;
    logic             rst_a, rst_b;
    logic             req_a, req_b;
    logic             wr;
    op_enum_dmem_size size;
    logic             zx;
    logic [31:0]      addr;
    logic [31:0]      wdata;

    logic             ready_a, rvalid_a, err_a;
    logic [31:0]      rdata_a;
    logic             ready_b, rvalid_b, err_b;
    logic [31:0]      rdata_b;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_ma [4096];
    logic [7:0]  mem_mb [256];
    logic [31:0] last_rd [2];

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_a (
        .clk (clk), .rst_n (rst_a), .dmem_req (req_a), .dmem_wr (wr), .dmem_size (size),
        .dmem_zero_ex (zx), .dmem_addr (addr), .dmem_wdata (wdata), .dmem_ready (ready_a),
        .dmem_rvalid (rvalid_a), .dmem_rdata (rdata_a), .dmem_err (err_a)
    );

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(64), .WAIT_STATES(2)) dut_b (
        .clk (clk), .rst_n (rst_b), .dmem_req (req_b), .dmem_wr (wr), .dmem_size (size),
        .dmem_zero_ex (zx), .dmem_addr (addr), .dmem_wdata (wdata), .dmem_ready (ready_b),
        .dmem_rvalid (rvalid_b), .dmem_rdata (rdata_b), .dmem_err (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, range check, split rule from address math
    task automatic model(input bit sel, input bit wr_i, input op_enum_dmem_size sz, input bit zx_i,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] erd,
                         output logic eer, output int elat);
        int n, lim, w;
        longint top;
        logic [31:0] v;
        n   = (sz == OP_DMEM_BYTE) ? 1 : (sz == OP_DMEM_HALF) ? 2 : 4;
        lim = sel ? 256 : 4096;
        w   = sel ? 2 : 0;
        top = longint'(a) + n - 1;
        if (top >= lim) begin
            eer  = 1'b1;
            elat = 1;
            erd  = wr_i ? last_rd[sel] : 32'h0;
        end else begin
            eer  = 1'b0;
            elat = ((int'(a % 4) + n) > 4) ? 3 + 2*w : 2 + w;
            if (wr_i) begin
                for (int i = 0; i < n; i++) begin
                    if (sel) mem_mb[a+i] = d[8*i +: 8];
                    else     mem_ma[a+i] = d[8*i +: 8];
                end
                erd = last_rd[sel];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = sel ? mem_mb[a+i] : mem_ma[a+i];
                if (!zx_i && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                erd = v;
            end
        end
        last_rd[sel] = erd;
    endtask

    task automatic xfer(input bit sel, input bit wr_i, input op_enum_dmem_size sz, input bit zx_i,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat, output bit busy_rdy, output bit rdy0);
        @(negedge clk);
        rdy0 = sel ? ready_b : ready_a;
        wr = wr_i; size = sz; zx = zx_i; addr = a; wdata = d;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        addr = $urandom(); wdata = $urandom(); zx = ~zx_i; wr = ~wr_i;
        busy_rdy = sel ? ready_b : ready_a;
        lat = 0; rd = 'x; er = 'x;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (sel ? rvalid_b : rvalid_a) begin
                lat = i;
                rd  = sel ? rdata_b : rdata_a;
                er  = sel ? err_b : err_a;
                break;
            end
            if (sel ? ready_b : ready_a) busy_rdy = 1'b1;
        end
    endtask

    task automatic op(input string tag, input bit sel, input bit wr_i, input op_enum_dmem_size sz,
                      input bit zx_i, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
        logic [31:0] erd;
        logic eer;
        int elat;
        bit busy, rdy0;
        model(sel, wr_i, sz, zx_i, a, d, erd, eer, elat);
        xfer(sel, wr_i, sz, zx_i, a, d, rd, er, lat, busy, rdy0);
        chk({tag, ".ready_idle"}, 32'(rdy0), 32'd1);
        chk({tag, ".ready_busy"}, 32'(busy), 32'd0);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".err"}, 32'(er), 32'(eer));
        chk({tag, ".rdata"}, rd, erd);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(sel ? rvalid_b : rvalid_a), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, first, second;
        bit early;
        op_enum_dmem_size sz;
        logic [31:0] a;

        rst_a = 0; rst_b = 0; req_a = 0; req_b = 0;
        wr = 0; size = OP_DMEM_WORD; zx = 0; addr = 0; wdata = 0;
        for (int i = 0; i < 4096; i++) mem_ma[i] = 8'h0;
        for (int i = 0; i < 256; i++)  mem_mb[i] = 8'h0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready_a", 32'(ready_a), 32'd1);
        chk("rst.rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst.rdata_a", rdata_a, 32'h0);
        chk("rst.err_a", 32'(err_a), 32'd0);
        chk("rst.ready_b", 32'(ready_b), 32'd1);
        chk("rst.rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst.rdata_b", rdata_b, 32'h0);
        chk("rst.err_b", 32'(err_b), 32'd0);
        rst_a = 1; rst_b = 1;

        for (int i = 0; i < 1024; i++) op("init_a", 0, 1, OP_DMEM_WORD, 0, 32'(4*i), 0, rd, er, lat);
        for (int i = 0; i < 64; i++)   op("init_b", 1, 1, OP_DMEM_WORD, 0, 32'(4*i), 0, rd, er, lat);

        // Aligned word store/load
        op("t1_sw", 0, 1, OP_DMEM_WORD, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("t1_sw.lat", lat, 2);
        op("t1_lw", 0, 0, OP_DMEM_WORD, 0, 32'h10, 0, rd, er, lat);
        chk("t1_lw.data", rd, 32'hDEADBEEF);
        chk("t1_lw.err", 32'(er), 32'd0);
        chk("t1_lw.lat", lat, 2);

        // Sub-word loads with both extensions
        op("t2_lb13", 0, 0, OP_DMEM_BYTE, 0, 32'h13, 0, rd, er, lat);
        chk("t2_lb13.data", rd, 32'hFFFFFFDE);
        op("t2_lbu13", 0, 0, OP_DMEM_BYTE, 1, 32'h13, 0, rd, er, lat);
        chk("t2_lbu13.data", rd, 32'h000000DE);
        op("t2_lh12", 0, 0, OP_DMEM_HALF, 0, 32'h12, 0, rd, er, lat);
        chk("t2_lh12.data", rd, 32'hFFFFDEAD);
        op("t2_lhu12", 0, 0, OP_DMEM_HALF, 1, 32'h12, 0, rd, er, lat);
        chk("t2_lhu12.data", rd, 32'h0000DEAD);
        op("t2_lb10", 0, 0, OP_DMEM_BYTE, 0, 32'h10, 0, rd, er, lat);
        chk("t2_lb10.data", rd, 32'hFFFFFFEF);

        // Word-crossing word
        op("t3_sw", 0, 1, OP_DMEM_WORD, 0, 32'h21, 32'h11223344, rd, er, lat);
        chk("t3_sw.lat", lat, 3);
        op("t3_w20", 0, 0, OP_DMEM_WORD, 0, 32'h20, 0, rd, er, lat);
        chk("t3_w20.data", rd, 32'h22334400);
        op("t3_w24", 0, 0, OP_DMEM_WORD, 0, 32'h24, 0, rd, er, lat);
        chk("t3_w24.data", rd, 32'h00000011);
        op("t3_lw21", 0, 0, OP_DMEM_WORD, 0, 32'h21, 0, rd, er, lat);
        chk("t3_lw21.data", rd, 32'h11223344);
        chk("t3_lw21.lat", lat, 3);

        // Word-crossing half
        op("t4_sh", 0, 1, OP_DMEM_HALF, 0, 32'h03, 32'h5555ABCD, rd, er, lat);
        op("t4_b3", 0, 0, OP_DMEM_BYTE, 1, 32'h03, 0, rd, er, lat);
        chk("t4_b3.data", rd, 32'h000000CD);
        op("t4_b4", 0, 0, OP_DMEM_BYTE, 1, 32'h04, 0, rd, er, lat);
        chk("t4_b4.data", rd, 32'h000000AB);
        op("t4_lhu", 0, 0, OP_DMEM_HALF, 1, 32'h03, 0, rd, er, lat);
        chk("t4_lhu.data", rd, 32'h0000ABCD);
        op("t4_lh", 0, 0, OP_DMEM_HALF, 0, 32'h03, 0, rd, er, lat);
        chk("t4_lh.data", rd, 32'hFFFFABCD);

        // Range boundary
        op("t5_lw_oob", 0, 0, OP_DMEM_WORD, 0, 32'd4094, 0, rd, er, lat);
        chk("t5_lw_oob.err", 32'(er), 32'd1);
        chk("t5_lw_oob.data", rd, 32'h0);
        chk("t5_lw_oob.lat", lat, 1);
        op("t5_sb_oob", 0, 1, OP_DMEM_BYTE, 0, 32'd4096, 32'h77, rd, er, lat);
        chk("t5_sb_oob.err", 32'(er), 32'd1);
        op("t5_w0", 0, 0, OP_DMEM_WORD, 0, 32'h0, 0, rd, er, lat);
        chk("t5_w0.data", rd, 32'hCD000000);
        op("t5_lb_last", 0, 0, OP_DMEM_BYTE, 0, 32'd4095, 0, rd, er, lat);
        chk("t5_lb_last.err", 32'(er), 32'd0);

        for (int i = 0; i < 300; i++) begin
            sz = op_enum_dmem_size'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? 32'(4088 + $urandom_range(0, 12))
                                             : 32'($urandom_range(0, 63));
            op("rnd", 0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
               rd, er, lat);
        end

        // Two wait states
        op("t6_swa", 1, 1, OP_DMEM_WORD, 0, 32'h40, 32'hA1B2C3D4, rd, er, lat);
        op("t6_swb", 1, 1, OP_DMEM_WORD, 0, 32'h48, 32'h0BADF00D, rd, er, lat);
        op("t6_lw", 1, 0, OP_DMEM_WORD, 0, 32'h40, 0, rd, er, lat);
        chk("t6_lw.lat", lat, 4);
        chk("t6_lw.data", rd, 32'hA1B2C3D4);
        op("t6_sws", 1, 1, OP_DMEM_WORD, 0, 32'h31, 32'hCAFEF00D, rd, er, lat);
        op("t6_lws", 1, 0, OP_DMEM_WORD, 0, 32'h31, 0, rd, er, lat);
        chk("t6_lws.lat", lat, 7);
        chk("t6_lws.data", rd, 32'hCAFEF00D);

        // Request held high across a busy period
        @(negedge clk);
        wr = 0; size = OP_DMEM_WORD; zx = 0; addr = 32'h40; req_b = 1;
        @(posedge clk); #1;
        addr = 32'h48;
        first = 0; second = 0; early = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (rvalid_b) begin
                if (first == 0) begin
                    first = i;
                    chk("t6_hold.data1", rdata_b, 32'hA1B2C3D4);
                end else if (second == 0) begin
                    second = i;
                    chk("t6_hold.data2", rdata_b, 32'h0BADF00D);
                    req_b = 0;
                end
            end
            if (first == 0 && ready_b) early = 1;
            if (second != 0) break;
        end
        req_b = 0;
        chk("t6_hold.first", first, 4);
        chk("t6_hold.second", second, 9);
        chk("t6_hold.ready_busy", 32'(early), 32'd0);
        last_rd[1] = 32'h0BADF00D;
        @(posedge clk); #1;

        // Reset during the second beat of a split store
        @(negedge clk);
        wr = 1; size = OP_DMEM_WORD; zx = 0; addr = 32'h21; wdata = 32'h55667788; req_b = 1;
        @(posedge clk); #1;
        req_b = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 0;
        @(posedge clk); #1;
        chk("t6_rst.ready", 32'(ready_b), 32'd1);
        chk("t6_rst.rvalid", 32'(rvalid_b), 32'd0);
        rst_b = 1;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rvalid_b) early = 1;
        end
        chk("t6_rst.no_resp", 32'(early), 32'd0);
        chk("t6_rst.rdata", rdata_b, 32'h0);
        mem_mb[32'h21] = 8'h88; mem_mb[32'h22] = 8'h77; mem_mb[32'h23] = 8'h66;
        last_rd[1] = 32'h0;
        op("t6_rst_w20", 1, 0, OP_DMEM_WORD, 0, 32'h20, 0, rd, er, lat);
        chk("t6_rst_w20.data", rd, 32'h66778800);
        op("t6_rst_w24", 1, 0, OP_DMEM_WORD, 0, 32'h24, 0, rd, er, lat);
        chk("t6_rst_w24.data", rd, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
